config_chain_loader: RTL

CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

---
 rtl/config_if.sv | 12 +
 rtl/config_chain_loader.sv | 127 ++++++++++++
 2 files changed

// File: rtl/config_if.sv
// Config daisy-chain link: a word bus plus the strobe that shifts it one stage down the chain.
//   data_clk : shift strobe; every row stage captures on its rising edge
//   data_in  : word presented to stage 0
interface config_if #(
  parameter int unsigned DATA_W = 16
);
  logic              data_clk;
  logic [DATA_W-1:0] data_in;

  modport master (output data_clk, output data_in);
  modport slave  (input  data_clk, input  data_in);
endinterface

// File: rtl/config_chain_loader.sv
// Shadow register file that is serially loaded into the row-parameter config daisy chain.
// Software writes words into the shadow file; a start pulse shifts the whole file into the
// chain, highest stage first, so every word lands in its own stage after 3*NUM_ROWS shifts.
//
// Ports
//   clk      : single clock
//   reset    : synchronous, active-high reset
//   wr_en    : shadow-file write strobe (dropped while busy)
//   wr_row   : target row of the write (values >= NUM_ROWS are dropped)
//   wr_field : 0 = E_l, 1 = E_rev, 2 = address, 3 = illegal (dropped)
//   wr_data  : word to store
//   wr_ready : high when writes are accepted
//   start    : single-cycle load request (ignored while busy)
//   busy     : high while a load is in progress
//   done     : one-cycle pulse at load completion
//   cfg_out  : data_clk / data_in driven into row 0 of the chain
module config_chain_loader #(
  parameter int unsigned NUM_ROWS = 4,
  parameter int unsigned DATA_W   = 16,
  // One extra bit so out-of-range rows can be presented and rejected.
  localparam int unsigned RowW    = $clog2(NUM_ROWS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [RowW-1:0]   wr_row,
  input  logic [1:0]        wr_field,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              start,
  output logic              busy,
  output logic              done,
  config_if.master          cfg_out
);

  localparam int unsigned NumWords = 3 * NUM_ROWS;
  localparam int unsigned IdxW     = $clog2(NumWords);
  localparam logic [IdxW-1:0] TopIdx = IdxW'(NumWords - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StClkHi, StDone} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   k_q;
  logic [DATA_W-1:0] shadow_q [NumWords];
  logic              busy_q;
  logic              done_q;
  logic              data_clk_q;
  logic [DATA_W-1:0] data_in_q;

  logic [IdxW-1:0]   wr_idx;
  logic              wr_ok;
  logic [DATA_W-1:0] first_word;
  logic [IdxW-1:0]   k_dec;

  assign wr_idx = IdxW'((32'(wr_row) * 32'd3) + 32'(wr_field));
  assign wr_ok  = wr_en && !busy_q && (wr_field != 2'd3) && (32'(wr_row) < NUM_ROWS);
  assign k_dec  = k_q - 1'b1;

  // A write landing in the top stage on the start cycle must be the first word shifted,
  // so bypass the shadow file for that one case.
  assign first_word = (wr_ok && (wr_idx == TopIdx)) ? wr_data : shadow_q[TopIdx];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NumWords); i++) begin
        shadow_q[i] <= '0;
      end
    end else if (wr_ok) begin
      shadow_q[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      k_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_clk_q <= 1'b0;
      data_in_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StSetup;
            k_q        <= TopIdx;
            busy_q     <= 1'b1;
            data_clk_q <= 1'b0;
            data_in_q  <= first_word;
          end
        end
        StSetup: begin
          state_q    <= StClkHi;
          data_clk_q <= 1'b1;
        end
        StClkHi: begin
          data_clk_q <= 1'b0;
          if (k_q == '0) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            state_q   <= StSetup;
            k_q       <= k_dec;
            data_in_q <= shadow_q[k_dec];
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign wr_ready         = ~busy_q;
  assign cfg_out.data_clk = data_clk_q;
  assign cfg_out.data_in  = data_in_q;

endmodule
